// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the Triple-DES sequencer.
// Contents:
//   state_t  - sequencer FSM states (IDLE, LAUNCH, WAIT, FINISH)
//   DES_ENC / DES_DEC - mode encoding presented to the DES core
//   PASS_W / pass_t   - width and type of the pass index
package des_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic DES_ENC = 1'b0;
  localparam logic DES_DEC = 1'b1;

  localparam int PASS_W = 2;
  typedef logic [PASS_W-1:0] pass_t;

endpackage

// File: rtl/triple_des_sequencer_if.sv
// Bundle of the job-side and core-side signals of the Triple-DES sequencer.
// Job side  : start, decrypt, block_in, key1, key2 (requests)
//             busy, done, err, block_out (status and result)
// Core side : core_start, core_in, core_key, core_decrypt (launch)
//             core_done, core_out (core response)
// Modports  : slave  - the sequencer
//             master - the surroundings (block register, DES core, bench)
interface triple_des_sequencer_if;

  logic        start;
  logic        decrypt;
  logic [63:0] block_in;
  logic [63:0] key1;
  logic [63:0] key2;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] block_out;

  logic        core_start;
  logic [63:0] core_in;
  logic [63:0] core_key;
  logic        core_decrypt;
  logic        core_done;
  logic [63:0] core_out;

  modport slave (
    input  start, decrypt, block_in, key1, key2, core_done, core_out,
    output busy, done, err, block_out, core_start, core_in, core_key, core_decrypt
  );

  modport master (
    output start, decrypt, block_in, key1, key2, core_done, core_out,
    input  busy, done, err, block_out, core_start, core_in, core_key, core_decrypt
  );

endinterface

// File: rtl/des_pass_select.sv
// Combinational key/mode schedule for two-key Triple-DES (E-D-E / D-E-D).
// Ports:
//   pass         in  current pass index (0..2)
//   decrypt      in  latched job mode
//   key1, key2   in  latched job keys
//   core_key     out key for this pass (k1, k2, k1)
//   core_decrypt out mode for this pass (job mode, inverted, job mode)
// With PASSES=1 it always selects key1 and the job mode.
module des_pass_select
  import des_ctrl_pkg::*;
#(
  parameter int PASSES = 3
) (
  input  pass_t       pass,
  input  logic        decrypt,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  output logic [63:0] core_key,
  output logic        core_decrypt
);

  always_comb begin
    core_key     = key1;
    core_decrypt = decrypt;
    // Only the middle pass differs: second key, opposite direction.
    if ((PASSES > 1) && (pass == pass_t'(1))) begin
      core_key     = key2;
      core_decrypt = (decrypt == DES_DEC) ? DES_ENC : DES_DEC;
    end
  end

endmodule

// File: rtl/triple_des_sequencer.sv
// Iterative Triple-DES controller time-sharing one external single-DES core.
// A job (block, keys, mode) is latched on start in IDLE; the core is then
// launched once per pass, each result feeding the next pass, and a one-cycle
// done pulse presents the final block.
// Ports:
//   CLOCK_50  in  system clock (rising edge)
//   rst       in  asynchronous active-high reset
//   bus       slave modport of triple_des_sequencer_if (job + core signals)
// Parameters:
//   PASSES  3 = Triple-DES, 1 = single DES with key1
//   TIMEOUT cycles to wait for core_done in one pass before aborting with err
//   TW      timer width, 2**TW > TIMEOUT
module triple_des_sequencer
  import des_ctrl_pkg::*;
#(
  parameter int PASSES  = 3,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic                   CLOCK_50,
  input logic                   rst,
  triple_des_sequencer_if.slave bus
);

  state_t        state;
  state_t        state_nxt;
  pass_t         pass;
  logic [TW-1:0] timer;
  logic [63:0]   data_reg;
  logic [63:0]   k1_reg;
  logic [63:0]   k2_reg;
  logic          dec_reg;
  logic          err_reg;
  logic [63:0]   out_reg;
  logic [63:0]   sel_key;
  logic          sel_dec;
  logic          last_pass;
  logic          timeout;

  assign last_pass = (pass == pass_t'(PASSES - 1));
  // The timer counts completed WAIT cycles; this flags the last allowed one.
  assign timeout   = (timer == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        // core_done takes priority over a coincident timeout.
        if (bus.core_done) state_nxt = last_pass ? FINISH : LAUNCH;
        else if (timeout)  state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.busy       = (state != IDLE);
    bus.done       = (state == FINISH);
    bus.core_start = (state == LAUNCH);
  end

  // Job registers, pass index, per-pass timer and result capture
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      pass     <= '0;
      timer    <= '0;
      data_reg <= '0;
      k1_reg   <= '0;
      k2_reg   <= '0;
      dec_reg  <= DES_ENC;
      err_reg  <= 1'b0;
      out_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_reg <= bus.block_in;
            k1_reg   <= bus.key1;
            k2_reg   <= bus.key2;
            dec_reg  <= bus.decrypt;
            pass     <= '0;
            err_reg  <= 1'b0;
          end
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          if (bus.core_done) begin
            data_reg <= bus.core_out;
            // Loaded on entry to FINISH so the result is visible with done.
            if (last_pass) out_reg <= bus.core_out;
            else           pass    <= pass + pass_t'(1);
          end else begin
            timer <= timer + TW'(1);
            if (timeout) begin
              err_reg <= 1'b1;
              out_reg <= data_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  des_pass_select #(
    .PASSES (PASSES)
  ) u_pass_select (
    .pass         (pass),
    .decrypt      (dec_reg),
    .key1         (k1_reg),
    .key2         (k2_reg),
    .core_key     (sel_key),
    .core_decrypt (sel_dec)
  );

  // data_reg only changes on core_done or in IDLE, so the core inputs stay
  // stable from launch until the core answers.
  assign bus.core_in      = data_reg;
  assign bus.core_key     = sel_key;
  assign bus.core_decrypt = sel_dec;
  assign bus.err          = err_reg;
  assign bus.block_out    = out_reg;

endmodule

// File: tb/tb_triple_des_sequencer.sv
// Self-checking bench for triple_des_sequencer and des_pass_select.
// Two sequencer instances (PASSES=3 and PASSES=1) each talk to a behavioural
// DES core built on a bit-level DES model; the PASSES=3 core has a
// programmable latency and can be told never to answer.
module tb_triple_des_sequencer;

  logic CLOCK_50;
  logic rst;

  triple_des_sequencer_if bus3 ();
  triple_des_sequencer_if bus1 ();

  triple_des_sequencer #(.PASSES(3), .TIMEOUT(255), .TW(8)) u_dut3 (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bus      (bus3)
  );

  triple_des_sequencer #(.PASSES(1), .TIMEOUT(255), .TW(8)) u_dut1 (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bus      (bus1)
  );

  logic [1:0]  ps_pass;
  logic        ps_dec;
  logic [63:0] ps_k1;
  logic [63:0] ps_k2;
  logic [63:0] ps_key;
  logic        ps_mode;

  des_pass_select #(.PASSES(3)) u_sel (
    .pass         (ps_pass),
    .decrypt      (ps_dec),
    .key1         (ps_k1),
    .key2         (ps_k2),
    .core_key     (ps_key),
    .core_decrypt (ps_mode)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // DES tables (FIPS 46-3)
  int pc1_t [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                     10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  int pc2_t [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                     23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                     41,52,31,37,47,55,30,40,51,45,33,48,
                     44,49,39,56,34,53,46,42,50,36,29,32};
  int ip_t [64]  = '{58,50,42,34,26,18,10, 2,60,52,44,36,28,20,12, 4,
                     62,54,46,38,30,22,14, 6,64,56,48,40,32,24,16, 8,
                     57,49,41,33,25,17, 9, 1,59,51,43,35,27,19,11, 3,
                     61,53,45,37,29,21,13, 5,63,55,47,39,31,23,15, 7};
  int p_t [32]   = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                      2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sb_t [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  // Bit-level single DES; DES bit n (1 = leftmost) is vector bit 64-n.
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] key,
                                            input logic dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] sk [16];
    logic [63:0] ipv, pre, res;
    logic [31:0] l, r, f, so, t;
    logic [47:0] ex;
    logic [5:0]  six;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < sh_t[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[rd][47-i] = cd[56-pc2_t[i]];
    end
    for (int i = 0; i < 64; i++) ipv[63-i] = blk[64-ip_t[i]];
    l = ipv[63:32];
    r = ipv[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int i = 0; i < 48; i++) ex[47-i] = r[31 - ((4*(i/6) + (i%6) + 31) % 32)];
      ex = ex ^ (dec ? sk[15-rd] : sk[rd]);
      for (int s = 0; s < 8; s++) begin
        six = ex[47-6*s -: 6];
        so[31-4*s -: 4] = 4'(sb_t[64*s + 16*int'({six[5], six[0]}) + int'(six[4:1])]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = so[32-p_t[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[64-ip_t[i]] = pre[63-i];
    return res;
  endfunction

  // Behavioural core for the PASSES=1 instance: fixed latency 1.
  always @(posedge CLOCK_50) begin
    if (rst) begin
      bus1.core_done <= 1'b0;
    end else begin
      bus1.core_done <= bus1.core_start;
      if (bus1.core_start)
        bus1.core_out <= des_model(bus1.core_in, bus1.core_key, bus1.core_decrypt);
    end
  end

  // Behavioural core for the PASSES=3 instance: latency lat3, hang3 = silent.
  int          lat3 = 1;
  bit          hang3 = 1'b0;
  int          l3_n = 0;
  int          hold_err = 0;
  logic        l3_mode [64];
  logic [63:0] l3_key [64];
  logic [63:0] c3_in, c3_key;
  logic        c3_mode;
  bit          c3_act;
  int          c3_cnt;

  always @(posedge CLOCK_50) begin
    if (rst) begin
      c3_act         <= 1'b0;
      bus3.core_done <= 1'b0;
    end else begin
      bus3.core_done <= 1'b0;
      if (bus3.core_start) begin
        l3_mode[l3_n % 64] <= bus3.core_decrypt;
        l3_key[l3_n % 64]  <= bus3.core_key;
        l3_n    <= l3_n + 1;
        c3_in   <= bus3.core_in;
        c3_key  <= bus3.core_key;
        c3_mode <= bus3.core_decrypt;
        c3_cnt  <= lat3 - 1;
        if (hang3) begin
          c3_act <= 1'b0;
        end else if (lat3 <= 1) begin
          bus3.core_done <= 1'b1;
          bus3.core_out  <= des_model(bus3.core_in, bus3.core_key, bus3.core_decrypt);
          c3_act         <= 1'b0;
        end else begin
          c3_act <= 1'b1;
        end
      end else if (c3_act) begin
        if (bus3.core_in !== c3_in || bus3.core_key !== c3_key || bus3.core_decrypt !== c3_mode)
          hold_err <= hold_err + 1;
        if (c3_cnt == 1) begin
          bus3.core_done <= 1'b1;
          bus3.core_out  <= des_model(c3_in, c3_key, c3_mode);
          c3_act         <= 1'b0;
        end
        c3_cnt <= c3_cnt - 1;
      end
    end
  end

  int job_base;

  function automatic logic [2:0] modes3(input int b);
    return {l3_mode[b % 64], l3_mode[(b+1) % 64], l3_mode[(b+2) % 64]};
  endfunction

  // Runs one job on the PASSES=3 instance. Returns at the negedge of the done
  // cycle (or when the bound expires) with n = cycles since start was sampled.
  // poke pulses start during pass-0 WAIT and leaves it high in the done cycle.
  task automatic run3(input logic [63:0] blk, input logic [63:0] k1, input logic [63:0] k2,
                      input logic dec, input bit poke,
                      output logic [63:0] res, output int n, output logic e1);
    job_base = l3_n;
    @(negedge CLOCK_50);
    bus3.block_in = blk;
    bus3.key1     = k1;
    bus3.key2     = k2;
    bus3.decrypt  = dec;
    bus3.start    = 1'b1;
    @(negedge CLOCK_50);
    n = 1;
    e1 = bus3.err;
    bus3.start    = 1'b0;
    bus3.block_in = ~blk;
    bus3.key1     = ~k1;
    bus3.key2     = ~k2;
    bus3.decrypt  = ~dec;
    while (bus3.done !== 1'b1 && n < 2000) begin
      if (poke) bus3.start = (n == 3);
      @(negedge CLOCK_50);
      n++;
    end
    bus3.start = poke && (bus3.done === 1'b1);
    res = bus3.block_out;
  endtask

  localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1   = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2B  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;

  logic        exp_m [2][3] = '{'{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b1}};
  int          exp_k [3]    = '{1, 2, 1};

  initial begin
    logic [63:0] res, enc_exp, exp;
    logic        e1;
    int          n, extra;

    rst = 1'b1;
    bus3.start = 1'b0; bus3.decrypt = 1'b0; bus3.block_in = '0; bus3.key1 = '0; bus3.key2 = '0;
    bus1.start = 1'b0; bus1.decrypt = 1'b0; bus1.block_in = '0; bus1.key1 = '0; bus1.key2 = '0;
    ps_k1 = 64'hAAAA_1111_AAAA_1111;
    ps_k2 = 64'h5555_2222_5555_2222;

    // Standalone schedule table
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 3; p++) begin
        ps_pass = 2'(p);
        ps_dec  = d[0];
        #1;
        check_val($sformatf("sel_key_d%0d_p%0d", d, p), ps_key, (exp_k[p] == 1) ? ps_k1 : ps_k2);
        check_val($sformatf("sel_mode_d%0d_p%0d", d, p), ps_mode, exp_m[d][p]);
      end
    end

    // Reset state
    repeat (2) @(negedge CLOCK_50);
    check_val("rst_ctl3", {bus3.busy, bus3.done, bus3.err, bus3.core_start, bus3.core_decrypt}, 0);
    check_val("rst_block_out3", bus3.block_out, 0);
    check_val("rst_core_in3", bus3.core_in, 0);
    check_val("rst_core_key3", bus3.core_key, 0);
    check_val("rst_ctl1", {bus1.busy, bus1.done, bus1.err, bus1.core_start, bus1.core_decrypt}, 0);
    rst = 1'b0;

    // PASSES=1 single DES
    @(negedge CLOCK_50);
    bus1.block_in = PT; bus1.key1 = K1; bus1.key2 = 64'h0; bus1.decrypt = 1'b0; bus1.start = 1'b1;
    @(negedge CLOCK_50);
    n = 1;
    bus1.start = 1'b0; bus1.block_in = '0; bus1.key1 = '0;
    while (bus1.done !== 1'b1 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_val("p1_latency", n, 3);
    check_val("p1_block_out", bus1.block_out, CT1);
    check_val("p1_err", bus1.err, 0);
    @(negedge CLOCK_50);
    check_val("p1_done_pulse", {bus1.done, bus1.busy}, 0);
    check_val("p1_out_held", bus1.block_out, CT1);

    // EDE with k1=k2 degenerates to single DES
    lat3 = 1;
    run3(PT, K1, K1, 1'b0, 1'b0, res, n, e1);
    check_val("ede_same_latency", n, 7);
    check_val("ede_same_out", res, CT1);
    check_val("ede_same_launches", l3_n - job_base, 3);
    check_val("ede_same_modes", modes3(job_base), 3'b010);
    @(negedge CLOCK_50);
    check_val("ede_same_idle", {bus3.done, bus3.busy}, 0);

    // Encrypt with k2=0, then decrypt the result back
    enc_exp = des_model(des_model(des_model(PT, K1, 1'b0), 64'h0, 1'b1), K1, 1'b0);
    lat3 = 2;
    run3(PT, K1, 64'h0, 1'b0, 1'b0, res, n, e1);
    check_val("enc_latency", n, 10);
    check_val("enc_out", res, enc_exp);
    check_val("enc_keys", {l3_key[job_base % 64], l3_key[(job_base+1) % 64],
                           l3_key[(job_base+2) % 64]} == {K1, 64'h0, K1}, 1);
    run3(enc_exp, K1, 64'h0, 1'b1, 1'b0, res, n, e1);
    check_val("dec_latency", n, 10);
    check_val("dec_out", res, PT);
    check_val("dec_modes", modes3(job_base), 3'b101);
    check_val("dec_keys", {l3_key[job_base % 64], l3_key[(job_base+1) % 64],
                           l3_key[(job_base+2) % 64]} == {K1, 64'h0, K1}, 1);

    // Core never answers: timeout with partial result
    hang3 = 1'b1;
    run3(PT, K1, K1, 1'b0, 1'b0, res, n, e1);
    check_val("to_latency", n, 257);
    check_val("to_err", bus3.err, 1);
    check_val("to_partial", res, PT);
    check_val("to_launches", l3_n - job_base, 1);
    @(negedge CLOCK_50);
    check_val("to_err_sticky", {bus3.err, bus3.done, bus3.busy}, 3'b100);
    hang3 = 1'b0;
    lat3 = 1;
    run3(PT, K1, K1, 1'b0, 1'b0, res, n, e1);
    check_val("to_err_cleared", e1, 0);
    check_val("to_next_out", res, CT1);
    check_val("to_next_err", bus3.err, 0);

    // start during WAIT and in the done cycle is ignored
    lat3 = 3;
    run3(PT, K1, 64'h0, 1'b0, 1'b1, res, n, e1);
    check_val("poke_latency", n, 13);
    check_val("poke_out", res, enc_exp);
    check_val("poke_modes", modes3(job_base), 3'b010);
    @(negedge CLOCK_50);
    bus3.start = 1'b0;
    check_val("poke_idle", {bus3.done, bus3.busy}, 0);
    extra = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (bus3.done === 1'b1 || bus3.busy === 1'b1) extra++;
    end
    check_val("poke_no_rerun", extra, 0);
    check_val("poke_launches", l3_n - job_base, 3);

    // Asynchronous reset in pass-1 WAIT
    job_base = l3_n;
    @(negedge CLOCK_50);
    bus3.block_in = PT; bus3.key1 = K1; bus3.key2 = K2B; bus3.decrypt = 1'b0; bus3.start = 1'b1;
    @(negedge CLOCK_50);
    bus3.start = 1'b0;
    n = 0;
    while (l3_n - job_base < 2 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check_val("mid_pass1_mode", {bus3.busy, bus3.core_decrypt, bus3.core_start}, 3'b110);
    rst = 1'b1;
    #1;
    check_val("mid_rst_ctl", {bus3.busy, bus3.done, bus3.err, bus3.core_start, bus3.core_decrypt}, 0);
    check_val("mid_rst_core_in", bus3.core_in, 0);
    check_val("mid_rst_core_key", bus3.core_key, 0);
    check_val("mid_rst_block_out", bus3.block_out, 0);
    @(negedge CLOCK_50);
    rst = 1'b0;
    exp = des_model(des_model(des_model(PT, K1, 1'b1), K2B, 1'b0), K1, 1'b1);
    run3(PT, K1, K2B, 1'b1, 1'b0, res, n, e1);
    check_val("post_rst_latency", n, 13);
    check_val("post_rst_out", res, exp);
    check_val("post_rst_modes", modes3(job_base), 3'b101);

    check_val("core_inputs_held", hold_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

endmodule
